// File: rtl/sign_narrow_if.sv
// sign_narrow_if: handshake bundle for sign_narrow
//   in_valid/in_ready/in_data/sat_mode : upstream full-width words and narrowing mode
//   out_valid/out_ready/out_data/out_fits : downstream narrowed field and fit flag
//   clear_count/ovf_count : overflow event counter control and status
interface sign_narrow_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             sat_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_fits;
    logic             clear_count;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, in_data, sat_mode, out_ready, clear_count,
        input  in_ready, out_valid, out_data, out_fits, ovf_count
    );

    modport slave (
        input  in_valid, in_data, sat_mode, out_ready, clear_count,
        output in_ready, out_valid, out_data, out_fits, ovf_count
    );
endinterface

// File: rtl/sign_narrow.sv
// sign_narrow: narrows signed IN_W words to OUT_W fields (saturate or wrap) through a 2-entry FIFO
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : in_* accept side, out_* head-of-FIFO side, clear_count/ovf_count overflow counter
module sign_narrow #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
) (
    input logic        clock,
    input logic        reset_n,
    sign_narrow_if.slave bus
);
    logic [IN_W-OUT_W:0] hi;
    logic                fits;
    logic [OUT_W-1:0]    sat_val;
    logic [OUT_W-1:0]    narrow;
    logic                push;
    logic                pop;
    logic [OUT_W:0]      mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          cnt;
    logic [CNT_W-1:0]    ovf;

    // The value fits when every bit from the MSB down to the narrow sign bit matches.
    assign hi      = bus.in_data[IN_W-1:OUT_W-1];
    assign fits    = (&hi) | ~(|hi);
    assign sat_val = bus.in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    assign narrow  = (!fits && bus.sat_mode) ? sat_val : bus.in_data[OUT_W-1:0];

    // in_ready depends only on the registered count, never on out_ready.
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = cnt != 2'd2;
    assign bus.out_valid = cnt != 2'd0;
    assign {bus.out_data, bus.out_fits} = mem[rd_ptr];
    assign bus.ovf_count = ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            ovf    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {narrow, fits};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            // Clear wins over a same-cycle overflow; the counter sticks at all-ones.
            if (bus.clear_count)
                ovf <= '0;
            else if (push && !fits && ovf != '1)
                ovf <= ovf + 1'b1;
        end
    end
endmodule

// File: tb/tb_sign_narrow.sv
// tb_sign_narrow: scoreboard bench for sign_narrow
module tb_sign_narrow;
    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_fail;
    int   exp_ovf;
    logic [4:0] q[$];

    sign_narrow_if #(.IN_W(16), .OUT_W(4), .CNT_W(8)) bif ();
    sign_narrow #(.IN_W(16), .OUT_W(4), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference narrowing from the integer value range, returned as {data, fits}.
    function automatic logic [4:0] model(input logic [15:0] d, input logic s);
        int v;
        v = int'($signed(d));
        if (v >= -8 && v <= 7) return {d[3:0], 1'b1};
        if (s) return {(v < 0) ? 4'b1000 : 4'b0111, 1'b0};
        return {d[3:0], 1'b0};
    endfunction

    // One clock: records accept/pop seen before the edge, pushes the expected word, returns at the next negedge.
    task automatic step(output bit acc, output bit popd, output logic [4:0] got);
        logic [4:0] e;
        acc  = bif.in_valid && bif.in_ready;
        popd = bif.out_valid && bif.out_ready;
        got  = {bif.out_data, bif.out_fits};
        e    = model(bif.in_data, bif.sat_mode);
        if (acc) q.push_back(e);
        if (bif.clear_count) exp_ovf = 0;
        else if (acc && !e[0] && exp_ovf < 255) exp_ovf++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_chk++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", bif.out_valid, bif.in_ready);
        end
        n_chk++;
        if ({bif.out_data, bif.out_fits} !== 5'b0 || bif.ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: data=%b fits=%b ovf=%0d, want 0/0/0", bif.out_data, bif.out_fits, bif.ovf_count);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_fit();
        logic [15:0] w [2];
        bit acc, popd;
        logic [4:0] got, exp;
        w[0] = 16'h0005;
        w[1] = 16'hFFFA;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bif.in_valid = 1'b1;
            bif.in_data  = w[i];
            bif.sat_mode = i[0];
            step(acc, popd, got);
            bif.in_valid = 1'b0;
            n_chk++;
            if (!acc || bif.out_valid !== 1'b1 || {bif.out_data, bif.out_fits} !== (i == 0 ? 5'b0101_1 : 5'b1010_1)) begin
                n_fail++;
                $display("FAIL fit_latency: acc=%b valid=%b data=%b fits=%b, want 1/1/%b", acc, bif.out_valid, bif.out_data, bif.out_fits, (i == 0 ? 5'b0101_1 : 5'b1010_1));
            end
            step(acc, popd, got);
            if (popd) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL fit_pop: got %b want %b", got, exp);
                end
            end
        end
        n_chk++;
        if (q.size() != 0 || bif.ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL fit_ovf: pending=%0d ovf=%0d, want 0/0", q.size(), bif.ovf_count);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w [3];
        logic        s [3];
        bit acc, popd;
        logic [4:0] got, exp;
        w[0] = 16'h0009; s[0] = 1'b1;
        w[1] = 16'h0009; s[1] = 1'b0;
        w[2] = 16'h8000; s[2] = 1'b1;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.in_data  = w[i];
            bif.sat_mode = s[i];
            step(acc, popd, got);
            if (popd) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL ovf_pop: got %b want %b", got, exp);
                end
            end
        end
        bif.in_valid = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            step(acc, popd, got);
            if (popd) begin
                exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL ovf_pop: got %b want %b", got, exp);
                end
            end
        end
        n_chk++;
        if (q.size() != 0 || bif.ovf_count !== 8'd3) begin
            n_fail++;
            $display("FAIL ovf_count: pending=%0d ovf=%0d, want 0/3", q.size(), bif.ovf_count);
        end
    endtask

    task automatic test_backpressure();
        bit acc, popd;
        logic [4:0] got, exp;
        bit a [3];
        int pops;
        pops = 0;
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b1;
        bif.sat_mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.in_data = 16'(i + 1);
            step(acc, popd, got);
            a[i] = acc;
        end
        n_chk++;
        if (!a[0] || !a[1] || a[2] || bif.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: acc=%b%b%b in_ready=%b, want 110/0", a[0], a[1], a[2], bif.in_ready);
        end
        bif.out_ready = 1'b1;
        step(acc, popd, got);
        n_chk++;
        if (!popd || acc || bif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reopen: pop=%b acc=%b in_ready=%b, want 1/0/1", popd, acc, bif.in_ready);
        end
        if (popd) begin
            pops++;
            exp = 'x;
            if (q.size() > 0) exp = q.pop_front();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bp_pop: got %b want %b", got, exp);
            end
        end
        for (int i = 0; i < 8 && (q.size() > 0 || bif.in_valid); i++) begin
            step(acc, popd, got);
            if (acc) bif.in_valid = 1'b0;
            if (popd) begin
                pops++;
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL bp_pop: got %b want %b", got, exp);
                end
            end
        end
        bif.in_valid = 1'b0;
        n_chk++;
        if (pops != 3 || q.size() != 0 || bif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: pops=%0d pending=%0d valid=%b, want 3/0/0", pops, q.size(), bif.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit acc, popd;
        logic [4:0] got, exp;
        bif.out_ready = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_data   = 16'h0007;
        bif.sat_mode  = 1'b0;
        step(acc, popd, got);
        for (int i = 0; i < 10; i++) begin
            bif.in_data  = 16'(i * 3 - 14);
            bif.sat_mode = i[0];
            step(acc, popd, got);
            n_chk++;
            if (!acc || !popd || bif.in_ready !== 1'b1 || bif.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_flow[%0d]: acc=%b pop=%b in_ready=%b out_valid=%b, want all 1", i, acc, popd, bif.in_ready, bif.out_valid);
            end
            if (popd) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_pop[%0d]: got %b want %b", i, got, exp);
                end
            end
        end
        bif.in_valid = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            step(acc, popd, got);
            if (popd) begin
                exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_pop: got %b want %b", got, exp);
                end
            end
        end
        n_chk++;
        if (q.size() != 0 || bif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: pending=%0d valid=%b, want 0/0", q.size(), bif.out_valid);
        end
    endtask

    task automatic test_saturation();
        bit acc, popd;
        logic [4:0] got, exp;
        bif.out_ready = 1'b1;
        bif.in_valid  = 1'b1;
        for (int i = 0; i < 260; i++) begin
            bif.in_data  = i[1] ? 16'hC000 : 16'h4000;
            bif.sat_mode = i[0];
            step(acc, popd, got);
            if (popd) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                if (got !== exp) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sat_pop[%0d]: got %b want %b", i, got, exp);
                end
            end
        end
        n_chk++;
        if (bif.ovf_count !== 8'(exp_ovf) || exp_ovf != 255) begin
            n_fail++;
            $display("FAIL sat_count: ovf=%0d want %0d", bif.ovf_count, exp_ovf);
        end
        bif.in_data     = 16'h0100;
        bif.clear_count = 1'b1;
        step(acc, popd, got);
        bif.clear_count = 1'b0;
        bif.in_valid    = 1'b0;
        n_chk++;
        if (!acc || bif.ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clear: acc=%b ovf=%0d, want 1/0", acc, bif.ovf_count);
        end
        if (popd) void'(q.pop_front());
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            step(acc, popd, got);
            if (popd) begin
                exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sat_pop: got %b want %b", got, exp);
                end
            end
        end
        n_chk++;
        if (q.size() != 0 || bif.ovf_count !== 8'(exp_ovf)) begin
            n_fail++;
            $display("FAIL sat_drain: pending=%0d ovf=%0d want 0/%0d", q.size(), bif.ovf_count, exp_ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit acc, popd;
        logic [4:0] got, exp;
        bif.out_ready = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_data   = 16'h7000;
        bif.sat_mode  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc, popd, got);
            if (popd) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                n_chk++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rst_pre_pop: got %b want %b", got, exp);
                end
            end
        end
        bif.out_ready = 1'b0;
        bif.in_data   = 16'h0001;
        step(acc, popd, got);
        if (popd) void'(q.pop_front());
        bif.in_data = 16'h0002;
        step(acc, popd, got);
        bif.in_data = 16'h0003;
        step(acc, popd, got);
        bif.in_valid = 1'b0;
        n_chk++;
        if (bif.in_ready !== 1'b0 || bif.ovf_count !== 8'd5 || q.size() != 2) begin
            n_fail++;
            $display("FAIL rst_setup: in_ready=%b ovf=%0d pending=%0d, want 0/5/2", bif.in_ready, bif.ovf_count, q.size());
        end
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_async: out_valid=%b in_ready=%b ovf=%0d, want 0/1/0", bif.out_valid, bif.in_ready, bif.ovf_count);
        end
        q.delete();
        exp_ovf = 0;
        #1 reset_n = 1'b1;
        @(negedge clock);
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(acc, popd, got);
            n_chk++;
            if (popd || bif.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale[%0d]: pop=%b out_valid=%b data=%b, want 0/0", i, popd, bif.out_valid, bif.out_data);
            end
        end
    endtask

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        exp_ovf         = 0;
        bif.in_valid    = 1'b0;
        bif.in_data     = '0;
        bif.sat_mode    = 1'b0;
        bif.out_ready   = 1'b0;
        bif.clear_count = 1'b0;
        reset_n         = 1'b0;
        test_reset();
        test_fit();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
